// File: rtl/sumador_4bit_pkg.sv
// sumador_4bit_pkg: default operand width shared by the adder files
package sumador_4bit_pkg;
   localparam int SUM_WIDTH = 4;
endpackage

// File: rtl/sumador_1_bit.sv
// sumador_1_bit: single full adder cell of the ripple chain
module sumador_1_bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   logic p;
   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);
endmodule

// File: rtl/sumador_4bit.sv
// sumador_4bit: ripple-carry adder with a single registered output stage
module sumador_4bit
   import sumador_4bit_pkg::*;
#(
   parameter int WIDTH = SUM_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic [WIDTH:0]   S,
   output logic             COUT,
   output logic             OVF
);
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;
   assign c[0] = CIN;
   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_fa
         sumador_1_bit u_fa (
            .a (A[i]),
            .b (B[i]),
            .ci(c[i]),
            .s (s[i]),
            .co(c[i+1])
         );
      end
   endgenerate
   // Register the full-width sum; overflow compares the carries into and out of the MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S    <= '0;
         COUT <= 1'b0;
         OVF  <= 1'b0;
      end else begin
         S    <= {c[WIDTH], s};
         COUT <= c[WIDTH];
         OVF  <= c[WIDTH] ^ c[WIDTH-1];
      end
   end
endmodule

// File: tb/tb_sumador_4bit.sv
// tb_sumador_4bit: directed table, reset sequences and exhaustive sweep for sumador_4bit
module tb_sumador_4bit;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] A = 4'hF;
   logic [3:0] B = 4'hF;
   logic       CIN = 1'b1;
   logic [4:0] S;
   logic       COUT;
   logic       OVF;
   int n_checks = 0;
   int n_fail = 0;
   logic [4:0] prev_s;
   bit         prev_v = 0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [4:0] es;
      logic       ecout;
      logic       eovf;
   } vec_t;

   sumador_4bit dut (
      .clk (clk),
      .rst_n(rst_n),
      .A   (A),
      .B   (B),
      .CIN (CIN),
      .S   (S),
      .COUT(COUT),
      .OVF (OVF)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one operand set, verify the previous result held until now, then verify the new one
   task automatic step(input logic [3:0] a, input logic [3:0] b, input logic cin, input string tag);
      logic [4:0] es;
      logic       eovf;
      @(negedge clk);
      if (prev_v) chk({tag, " hold"}, 32'(S), 32'(prev_s));
      A = a;
      B = b;
      CIN = cin;
      es = 5'(a) + 5'(b) + 5'(cin);
      eovf = (a[3] == b[3]) && (es[3] != a[3]);
      @(posedge clk);
      #1;
      chk({tag, " S"}, 32'(S), 32'(es));
      chk({tag, " COUT"}, 32'(COUT), 32'(es[4]));
      chk({tag, " OVF"}, 32'(OVF), 32'(eovf));
      prev_s = es;
      prev_v = 1;
   endtask

   initial begin
      vec_t vecs[8];
      vecs[0] = '{4'h3, 4'h5, 1'b0, 5'h08, 1'b0, 1'b1};
      vecs[1] = '{4'hF, 4'h1, 1'b0, 5'h10, 1'b1, 1'b0};
      vecs[2] = '{4'hF, 4'hF, 1'b1, 5'h1F, 1'b1, 1'b0};
      vecs[3] = '{4'h0, 4'h0, 1'b1, 5'h01, 1'b0, 1'b0};
      vecs[4] = '{4'h7, 4'h1, 1'b0, 5'h08, 1'b0, 1'b1};
      vecs[5] = '{4'h8, 4'h8, 1'b0, 5'h10, 1'b1, 1'b1};
      vecs[6] = '{4'h8, 4'hF, 1'b0, 5'h17, 1'b1, 1'b1};
      vecs[7] = '{4'h5, 4'hA, 1'b1, 5'h10, 1'b1, 1'b0};
      #2;
      chk("reset S before edge", 32'(S), 32'h0);
      chk("reset COUT before edge", 32'(COUT), 32'h0);
      chk("reset OVF before edge", 32'(OVF), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset S held", 32'(S), 32'h0);
      chk("reset COUT held", 32'(COUT), 32'h0);
      chk("reset OVF held", 32'(OVF), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("release S", 32'(S), 32'h1F);
      chk("release COUT", 32'(COUT), 32'h1);
      chk("release OVF", 32'(OVF), 32'h0);
      prev_s = 5'h1F;
      prev_v = 1;
      for (int k = 0; k < 8; k++) begin
         step(vecs[k].a, vecs[k].b, vecs[k].cin, $sformatf("vec%0d", k));
         chk($sformatf("vec%0d table S", k), 32'(S), 32'(vecs[k].es));
         chk($sformatf("vec%0d table COUT", k), 32'(COUT), 32'(vecs[k].ecout));
         chk($sformatf("vec%0d table OVF", k), 32'(OVF), 32'(vecs[k].eovf));
      end
      step(4'hF, 4'hF, 1'b1, "pre-midreset");
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset S async", 32'(S), 32'h0);
      chk("midreset COUT async", 32'(COUT), 32'h0);
      @(posedge clk);
      #1;
      chk("midreset S held", 32'(S), 32'h0);
      @(negedge clk);
      A = 4'h2;
      B = 4'h4;
      CIN = 1'b1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("re-release S", 32'(S), 32'h07);
      chk("re-release OVF", 32'(OVF), 32'h0);
      prev_s = 5'h07;
      prev_v = 1;
      for (int c = 0; c < 2; c++)
         for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            step(v[3:0], v[7:4], c[0], $sformatf("sweep c%0d i%0d", c, i));
         end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
